// File: rtl/mem_access_unit.sv
// Load/store initiator between execute and a single-port synchronous data RAM; does RMW for sub-word stores.
// Latency accept->resp: error 1, word store 2, load 3, sub-word store 4 cycles; one request in flight.
// Backpressure: req_ready_o is high only in IDLE, so the next accept is no earlier than the cycle after RESP.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid_i / req_ready_o       request handshake (accept when both high)
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i   request fields, sampled at accept only
//   resp_valid_o, resp_rdata_o, resp_err_o                          one-cycle completion
//   dram_wea_o, dram_addra_o, dram_dina_o, dram_douta_i             RAM port (read data one cycle after address)

module mem_access_unit #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [WIDTH-1:0]      req_wdata_i,
    output logic                  resp_valid_o,
    output logic [WIDTH-1:0]      resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  dram_wea_o,
    output logic [ADDR_WIDTH-1:0] dram_addra_o,
    output logic [WIDTH-1:0]      dram_dina_o,
    input  logic [WIDTH-1:0]      dram_douta_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]            state;
    logic                  we_q;
    logic                  uns_q;
    logic [1:0]            size_q;
    logic [1:0]            off_q;
    logic [15:0]           wdata_q;
    logic [WIDTH-1:0]      rdata_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addra_q;
    logic [WIDTH-1:0]      dina_q;

    logic                  req_err;
    logic [4:0]            lane_shift;
    logic [WIDTH-1:0]      load_word;
    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [WIDTH-1:0]      load_ext;
    logic [WIDTH-1:0]      merged;

    always_comb begin
        req_err = 1'b0;
        case (req_size_i)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr_i[0];
            2'b10:   req_err = (req_addr_i[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    // Little-endian lanes: byte k at bits [8k+7:8k]; halves are 2-byte aligned so the
    // same shift selects half h = off[1].
    assign lane_shift = {off_q, 3'b000};
    assign load_word  = dram_douta_i >> lane_shift;
    assign load_byte  = load_word[7:0];
    assign load_half  = load_word[15:0];

    always_comb begin
        load_ext = load_word;
        case (size_q)
            2'b00:   load_ext = {{(WIDTH-8){~uns_q & load_byte[7]}}, load_byte};
            2'b01:   load_ext = {{(WIDTH-16){~uns_q & load_half[15]}}, load_half};
            default: load_ext = load_word;
        endcase
    end

    always_comb begin
        merged = dram_douta_i;
        if (size_q == 2'b00) begin
            merged[lane_shift +: 8] = wdata_q[7:0];
        end else begin
            merged[lane_shift +: 16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        uns_q   <= req_unsigned_i;
                        size_q  <= req_size_i;
                        off_q   <= req_addr_i[1:0];
                        wdata_q <= req_wdata_i[15:0];
                        rdata_q <= '0;
                        err_q   <= req_err;
                        if (req_err) begin
                            // RAM address is left untouched: errors never reach the memory.
                            state <= S_RESP;
                        end else begin
                            addra_q <= req_addr_i;
                            if (req_we_i && (req_size_i == 2'b10)) begin
                                dina_q <= req_wdata_i;
                                state  <= S_WRITE;
                            end else begin
                                state <= S_READ;
                            end
                        end
                    end
                end
                S_READ:  state <= S_DATA;
                S_DATA: begin
                    if (we_q) begin
                        dina_q <= merged;
                        state  <= S_WRITE;
                    end else begin
                        rdata_q <= load_ext;
                        state   <= S_RESP;
                    end
                end
                S_WRITE: state <= S_RESP;
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write enable decoded from state so the async reset removes it without waiting for an edge.
    assign dram_wea_o   = (state == S_WRITE);
    assign req_ready_o  = (state == S_IDLE);
    assign resp_valid_o = (state == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign dram_addra_o = addra_q;
    assign dram_dina_o  = dina_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural single-port RAM, vector table, response scoreboard.
// Latency measured per response; reset during a sub-word store's WRITE handled as a hand sequence.
// Inputs driven away from the rising edge; outputs sampled on the falling edge.

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dram_wea;
    logic [31:0] dram_addra;
    logic [31:0] dram_dina;
    logic [31:0] dram_douta;

    always #5 clk = ~clk;

    mem_access_unit #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .dram_wea_o     (dram_wea),
        .dram_addra_o   (dram_addra),
        .dram_dina_o    (dram_dina),
        .dram_douta_i   (dram_douta)
    );

    // Single-port RAM, word index = addr[11:2], read data registered.
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        dram_douta = 32'h0;
    end
    always @(posedge clk) begin
        if (dram_wea) mem[dram_addra[11:2]] <= dram_dina;
        dram_douta <= mem[dram_addra[11:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Write observer.
    int          wr_count = 0;
    logic [31:0] wr_addr  = 32'h0;
    logic [31:0] wr_dina  = 32'h0;
    always @(negedge clk) begin
        if (dram_wea) begin
            wr_count <= wr_count + 1;
            wr_addr  <= dram_addra;
            wr_dina  <= dram_dina;
        end
    end

    // Response scoreboard.
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        int          id;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'(resp_valid), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("v%0d_rdata", e.id), resp_rdata, e.rdata);
                check($sformatf("v%0d_err", e.id), 32'(resp_err), 32'(e.err));
                check($sformatf("v%0d_latency", e.id), 32'(cyc - e.acc), 32'(e.lat));
                check($sformatf("v%0d_ready_in_resp", e.id), 32'(req_ready), 32'h0);
            end
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic [31:0] dina;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                       input int lat, input logic [31:0] dina);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.dina = dina;
        vecs.push_back(v);
    endtask

    task automatic wait_ready(input int id);
        int k;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        if (!req_ready) check($sformatf("v%0d_ready_wait", id), 32'(req_ready), 32'h1);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int   k;
        int   wr0;
        int   exp_wr;
        exp_t e;
        wait_ready(id);
        if (!req_ready) return;
        wr0          = wr_count;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
        e.rdata = v.rdata; e.err = v.err; e.lat = v.lat; e.acc = cyc; e.id = id;
        sb.push_back(e);
        @(negedge clk);
        // Scramble the request bus after accept; it must have no effect.
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        #1;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            check($sformatf("v%0d_resp_timeout", id), 32'(sb.size()), 32'h0);
            sb.delete();
        end
        exp_wr = (v.we && !v.err) ? 1 : 0;
        check($sformatf("v%0d_nwrites", id), 32'(wr_count - wr0), 32'(exp_wr));
        if (exp_wr == 1) begin
            check($sformatf("v%0d_wr_addr", id), wr_addr, v.addr);
            check($sformatf("v%0d_wr_dina", id), wr_dina, v.dina);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t lw;
        int   k;

        //   we    size   uns   addr       wdata         rdata         err  lat  dina
        add(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 32'hDEADBEEF);
        add(1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 32'h0);
        add(1'b1, 2'd2, 1'b0, 32'h020, 32'h80FF7F01, 32'h00000000, 1'b0, 2, 32'h80FF7F01);
        add(1'b0, 2'd0, 1'b0, 32'h021, 32'h0,        32'h0000007F, 1'b0, 3, 32'h0);
        add(1'b0, 2'd0, 1'b0, 32'h023, 32'h0,        32'hFFFFFF80, 1'b0, 3, 32'h0);
        add(1'b0, 2'd0, 1'b1, 32'h023, 32'h0,        32'h00000080, 1'b0, 3, 32'h0);
        add(1'b0, 2'd1, 1'b0, 32'h022, 32'h0,        32'hFFFF80FF, 1'b0, 3, 32'h0);
        add(1'b0, 2'd1, 1'b1, 32'h022, 32'h0,        32'h000080FF, 1'b0, 3, 32'h0);
        add(1'b0, 2'd0, 1'b0, 32'h020, 32'h0,        32'h00000001, 1'b0, 3, 32'h0);
        add(1'b0, 2'd1, 1'b0, 32'h020, 32'h0,        32'h00007F01, 1'b0, 3, 32'h0);
        add(1'b0, 2'd0, 1'b0, 32'h022, 32'h0,        32'hFFFFFFFF, 1'b0, 3, 32'h0);
        add(1'b0, 2'd0, 1'b1, 32'h022, 32'h0,        32'h000000FF, 1'b0, 3, 32'h0);
        add(1'b1, 2'd2, 1'b0, 32'h030, 32'h11223344, 32'h00000000, 1'b0, 2, 32'h11223344);
        add(1'b1, 2'd0, 1'b0, 32'h032, 32'hFFFFFFAA, 32'h00000000, 1'b0, 4, 32'h11AA3344);
        add(1'b0, 2'd2, 1'b1, 32'h030, 32'h0,        32'h11AA3344, 1'b0, 3, 32'h0);
        add(1'b1, 2'd2, 1'b0, 32'h034, 32'hCAFEF00D, 32'h00000000, 1'b0, 2, 32'hCAFEF00D);
        add(1'b1, 2'd1, 1'b0, 32'h036, 32'h12345678, 32'h00000000, 1'b0, 4, 32'h5678F00D);
        add(1'b0, 2'd2, 1'b0, 32'h034, 32'h0,        32'h5678F00D, 1'b0, 3, 32'h0);
        add(1'b1, 2'd0, 1'b0, 32'h035, 32'h000000BB, 32'h00000000, 1'b0, 4, 32'h5678BB0D);
        add(1'b0, 2'd2, 1'b0, 32'h034, 32'h0,        32'h5678BB0D, 1'b0, 3, 32'h0);
        add(1'b0, 2'd1, 1'b0, 32'h041, 32'h0,        32'h00000000, 1'b1, 1, 32'h0);
        add(1'b1, 2'd2, 1'b0, 32'h042, 32'h55555555, 32'h00000000, 1'b1, 1, 32'h0);
        add(1'b0, 2'd3, 1'b0, 32'h040, 32'h0,        32'h00000000, 1'b1, 1, 32'h0);
        add(1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 32'h0);
        add(1'b1, 2'd3, 1'b0, 32'h044, 32'h66666666, 32'h00000000, 1'b1, 1, 32'h0);
        add(1'b0, 2'd2, 1'b0, 32'h012, 32'h0,        32'h00000000, 1'b1, 1, 32'h0);
        add(1'b1, 2'd1, 1'b0, 32'h033, 32'h00007777, 32'h00000000, 1'b1, 1, 32'h0);

        // Reset with a request held on the bus: it must be ignored.
        rst_n        = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_0100;
        req_wdata    = 32'h1234_5678;
        repeat (3) @(negedge clk);
        check("rst_ready",      32'(req_ready),  32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_err",   32'(resp_err),   32'h0);
        check("rst_resp_rdata", resp_rdata,      32'h0);
        check("rst_wea",        32'(dram_wea),   32'h0);
        check("rst_addra",      dram_addra,      32'h0);
        check("rst_dina",       dram_dina,       32'h0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk); #1;
        check("post_rst_nwrites", 32'(wr_count), 32'h0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset while a sub-word store sits in WRITE.
        wait_ready(100);
        req_we       = 1'b1;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h032;
        req_wdata    = 32'h00000055;
        req_valid    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        k = 0;
        while (!dram_wea && k < 10) begin
            @(negedge clk); #1;
            k++;
        end
        check("rstw_wea_seen", 32'(dram_wea), 32'h1);
        check("rstw_dina_pending", dram_dina, 32'h1155_3344);
        rst_n = 1'b0;
        #1;
        check("rstw_wea_drop",   32'(dram_wea),   32'h0);
        check("rstw_resp_valid", 32'(resp_valid), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstw_ready",    32'(req_ready), 32'h1);
        check("rstw_mem_word", mem[12],        32'h11AA3344);
        repeat (3) @(negedge clk);
        #1;
        check("rstw_mem_word_late", mem[12], 32'h11AA3344);

        lw.we = 1'b0; lw.size = 2'd2; lw.uns = 1'b0; lw.addr = 32'h030; lw.wdata = 32'h0;
        lw.rdata = 32'h11AA3344; lw.err = 1'b0; lw.lat = 3; lw.dina = 32'h0;
        run_vec(lw, 101);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator sitting between the execute stage and the data memory. It accepts one byte, halfword or word access at a time, and drives the data memory's single-port interface: one write-enable bit, a word-indexed address and a one-cycle synchronous read. It performs read-modify-write for sub-word stores, extracts and sign- or zero-extends load data, and rejects misaligned accesses.

## Interface
- `WIDTH`, 32: data word width; equals the global `WIDTH`.
- `ADDR_WIDTH`, 32: byte-address width; equals the global `ADDR_WIDTH`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  unit idle; a request is accepted on an edge where valid and ready are both high.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- `req_unsigned_i`  in  1  selects load extension: 1 = zero-extend, 0 = sign-extend.
- `req_addr_i`  in  ADDR_WIDTH  byte address.
- `req_wdata_i`  in  WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid_o`  out  1  one-cycle completion pulse.
- `resp_rdata_o`  out  WIDTH  extended load data; 0 for stores and errors.
- `resp_err_o`  out  1  misaligned access or reserved size; qualified by `resp_valid_o`.
- `dram_wea_o`  out  1  memory write enable.
- `dram_addra_o`  out  ADDR_WIDTH  byte address. The memory uses bits [11:2] as the word index.
- `dram_dina_o`  out  WIDTH  memory write data.
- `dram_douta_i`  in  WIDTH  memory read data, valid the cycle after the address is presented.

## Operation
- States: IDLE, READ, DATA, WRITE, RESP. `req_ready_o` = (state == IDLE).
- Acceptance in IDLE latches the address, size, unsigned flag, write flag and write data.
- Error check happens at accept. An access is an error if:
  - size is 11;
  - size is half and addr[0] = 1; or
  - size is word and addr[1:0] ≠ 00.
- An erroring access goes directly to RESP with `resp_err_o` = 1 and performs no memory access.
- Routing after accept:
  - word store: IDLE → WRITE;
  - load or sub-word store: IDLE → READ.
- READ: `dram_addra_o` = latched address, `dram_wea_o` = 0. Always → DATA.
- DATA: `dram_douta_i` is valid.
  - Load: select the lane and register the extended result, then → RESP.
  - Sub-word store: register the merged word, then → WRITE. The merged word is the read word with the addressed lane(s) replaced by `req_wdata_i`[7:0] or [15:0].
- WRITE: `dram_wea_o` = 1 for exactly one cycle, with `dram_dina_o` = full word or merged word. Always → RESP.
- RESP: `resp_valid_o` = 1 for one cycle → IDLE. No request is accepted in RESP.
- Lanes are little-endian:
  - byte k = addr[1:0] occupies bits [8k+7:8k];
  - half h = addr[1] occupies bits [16h+15:16h].
- Load extension: a signed byte replicates bit 7 into [31:8]; a signed half replicates bit 15 into [31:16]. Unsigned loads zero-fill. `req_unsigned_i` is ignored for word loads.
- `dram_addra_o` and `dram_dina_o` hold their last values outside READ and WRITE. `dram_wea_o` is 0 in every state other than WRITE.

## Timing
- Reset values:
  - state IDLE, so `req_ready_o` = 1;
  - `resp_valid_o` = 0, `resp_err_o` = 0, `resp_rdata_o` = 0;
  - `dram_wea_o` = 0, `dram_addra_o` = 0, `dram_dina_o` = 0.
- Requests are ignored while `rst_n` = 0.
- Latency, counted from the accept edge to the `resp_valid_o` cycle:
  - load: 3 cycles (READ, DATA, RESP);
  - word store: 2 cycles (WRITE, RESP);
  - sub-word store: 4 cycles (READ, DATA, WRITE, RESP);
  - error: 1 cycle.
- Throughput: one request per latency + 1 cycles. The next accept occurs no earlier than the IDLE cycle following RESP.
- A store's write is committed at the rising edge that ends WRITE. A load issued after a store's RESP observes the stored value.
- Reset mid-operation: the asynchronous reset drops `dram_wea_o` immediately. If reset asserts during WRITE before the edge, no write occurs and no response is produced; the unit returns to IDLE.
- Inputs are sampled only at the accept edge. Changes to `req_*` after acceptance have no effect.

## Test plan
- Word store then load:
  - store 0xDEADBEEF to 0x010 → `dram_wea_o` pulses once with addr 0x010 and dina 0xDEADBEEF; `resp_valid_o` 2 cycles after accept.
  - load word from 0x010 → `resp_rdata_o` = 0xDEADBEEF, 3 cycles after accept.
- Byte loads from word 0x80FF7F01 at 0x020:
  - LB at 0x021 → 0x0000007F;
  - LB at 0x023 → 0xFFFFFF80;
  - LBU at 0x023 → 0x00000080.
- Halfword loads from word 0x80FF7F01 at 0x020:
  - LH at 0x022 → 0xFFFF80FF;
  - LHU at 0x022 → 0x000080FF.
- Sub-word store: word 0x11223344 at 0x030, SB of 0xAA to 0x032 → the single write has dina 0x11AA3344; `resp_valid_o` 4 cycles after accept; a subsequent LW returns 0x11AA3344.
- Misaligned access: LH at 0x041, SW at 0x042 and size 11 → each gives `resp_err_o` = 1 one cycle after accept, `dram_wea_o` never asserts, and `resp_rdata_o` = 0.
- Reset during WRITE of a sub-word store: `dram_wea_o` falls immediately, the memory word is unchanged, no `resp_valid_o` is produced, and after release `req_ready_o` = 1 and the next load succeeds.
